// File: rtl/msg_schedule_gen.sv
// msg_schedule_gen: SHA-256 message schedule.
// Emits one W[t] per w_next strobe from a 16-word sliding window.
module msg_schedule_gen #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         w_init,
  input  logic         w_next,
  input  logic [511:0] block,
  output logic [31:0]  w_i,
  output logic [6:0]   round,
  output logic         busy,
  output logic         done
);
  logic [31:0] r_mem [16];
  logic [31:0] w_s0, w_s1, w_new;
  assign w_s0  = {r_mem[1][6:0], r_mem[1][31:7]} ^ {r_mem[1][17:0], r_mem[1][31:18]} ^ (r_mem[1] >> 3);
  assign w_s1  = {r_mem[14][16:0], r_mem[14][31:17]} ^ {r_mem[14][18:0], r_mem[14][31:19]} ^ (r_mem[14] >> 10);
  assign w_new = w_s1 + r_mem[9] + w_s0 + r_mem[0];
  assign w_i   = r_mem[0];
  // Words for rounds past 48 are still generated; the window simply runs on.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int j = 0; j < 16; j++) r_mem[j] <= '0;
      round <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (w_init) begin
      for (int j = 0; j < 16; j++) r_mem[j] <= block[511-32*j -: 32];
      round <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (w_next && busy) begin
      for (int j = 0; j < 15; j++) r_mem[j] <= r_mem[j+1];
      r_mem[15] <= w_new;
      round     <= round + 7'd1;
      if (round == 7'(ROUNDS - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_msg_schedule_gen.sv
// tb_msg_schedule_gen: random and directed checks of msg_schedule_gen
// against a full-array SHA-256 schedule model.
module tb_msg_schedule_gen;
  logic         clk = 1'b0;
  logic         Reset, w_init, w_next;
  logic [511:0] block;
  logic [31:0]  w_i;
  logic [6:0]   round;
  logic         busy, done;
  msg_schedule_gen dut (
    .clk(clk), .Reset(Reset), .w_init(w_init), .w_next(w_next), .block(block),
    .w_i(w_i), .round(round), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  logic [31:0] mw [0:64];
  int m_round;
  logic m_busy, m_done;
  logic [511:0] abc_blk, rnd_blk;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [31:0] sg0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sg1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom;
    return b;
  endfunction
  task automatic model_load(input logic [511:0] b);
    for (int t = 0; t < 16; t++) mw[t] = b[511-32*t -: 32];
    for (int t = 16; t <= 64; t++) mw[t] = sg1(mw[t-2]) + mw[t-7] + sg0(mw[t-15]) + mw[t-16];
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask
  task automatic check_all();
    chk("w_i", w_i, mw[m_round]);
    chk("round", {25'd0, round}, m_round);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
  endtask
  // One clock: drive on negedge, update model and compare just after posedge.
  task automatic cyc(input logic r, input logic i, input logic n, input logic [511:0] b);
    @(negedge clk);
    Reset = r; w_init = i; w_next = n;
    block = i ? b : rand_block();
    @(posedge clk);
    #1;
    if (r) begin
      model_load('0); m_round = 0; m_busy = 0; m_done = 0;
    end else if (i) begin
      model_load(b); m_round = 0; m_busy = 1; m_done = 0;
    end else if (n && m_busy) begin
      m_round++;
      if (m_round == 64) begin m_busy = 0; m_done = 1; end
    end
    check_all();
  endtask
  task automatic nexts(input int k, input int gap);
    for (int s = 0; s < k; s++) begin
      cyc(0, 0, 1, '0);
      for (int g = 0; g < gap; g++) cyc(0, 0, 0, '0);
    end
  endtask
  initial begin
    Reset = 1; w_init = 0; w_next = 0; block = '0;
    abc_blk = '0;
    abc_blk[511 -: 32] = 32'h61626380;
    abc_blk[31:0] = 32'h00000018;
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    chk("reset_w_i", w_i, 32'h0);
    nexts(3, 0);
    chk("idle_round", {25'd0, round}, 32'd0);
    cyc(0, 1, 0, abc_blk);
    chk("abc_w0", w_i, 32'h61626380);
    nexts(16, 0);
    chk("abc_w16", w_i, 32'h61626380);
    nexts(1, 0);
    chk("abc_w17", w_i, 32'h000F0000);
    nexts(1, 0);
    chk("abc_w18", w_i, 32'h7DA86405);
    nexts(45, 0);
    chk("abc_w63", w_i, 32'h12B1EDEB);
    chk("abc_r63", {25'd0, round}, 32'd63);
    nexts(1, 0);
    chk("done_r64", {25'd0, round}, 32'd64);
    chk("done_flag", {31'd0, done}, 32'd1);
    nexts(1, 0);
    chk("done_sticky", {31'd0, done}, 32'd1);
    cyc(0, 1, 0, abc_blk);
    chk("reinit_done", {31'd0, done}, 32'd0);
    nexts(20, 5);
    rnd_blk = rand_block();
    cyc(0, 1, 1, rnd_blk);
    chk("collide_w0", w_i, rnd_blk[511 -: 32]);
    nexts(30, 0);
    cyc(1, 0, 0, '0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    nexts(1, 0);
    cyc(0, 1, 0, rand_block());
    nexts(40, 0);
    cyc(0, 1, 0, {16{32'hFFFFFFFF}});
    chk("ff_w0", w_i, 32'hFFFFFFFF);
    nexts(16, 0);
    chk("ff_w16", w_i, 32'h203FFFFC);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, rand_block());
      nexts(66, $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
